// File: rtl/pipeline_hazard_controller.sv
// Pipeline sequencer: per-stage enables/flushes and PC write from hazard, branch, multi-cycle and halt events.
// Optional stall counter enabled with `define STALL_COUNTER_EN.
module pipeline_hazard_controller #(
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic                 LoadUseHazard,
  input  logic                 BranchTaken,
  input  logic                 MCStart,
  input  logic                 MCDone,
  input  logic                 HaltReq,
  input  logic                 ResumeReq,
`ifdef STALL_COUNTER_EN
  input  logic                 ClearCount,
  output logic [CNT_WIDTH-1:0] StallCount,
`endif
  output logic                 PCWrite,
  output logic                 EnIFID,
  output logic                 EnIDEX,
  output logic                 EnEXMEM,
  output logic                 EnMEMWB,
  output logic                 FlushIFID,
  output logic                 FlushIDEX,
  output logic                 FlushEXMEM,
  output logic                 MCBusy,
  output logic                 Timeout,
  output logic [1:0]           State
);

  localparam int CW = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MC_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_MC   = 2'b01,
    ST_HALT = 2'b10
  } state_e;

  state_e          state_q, state_d;
  logic            pend_q, pend_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            to_q, to_d;
  logic            busy_q;
  logic            pend_now;

  // Raw (ungated) controls: {PCWrite,EnIFID,EnIDEX,EnEXMEM,EnMEMWB,FlushIFID,FlushIDEX,FlushEXMEM}
  logic [7:0]      ctl;

  localparam logic [7:0] CTL_ALL  = 8'b11111_000;
  localparam logic [7:0] CTL_MC   = 8'b00011_001;
  localparam logic [7:0] CTL_BR   = 8'b11111_110;
  localparam logic [7:0] CTL_LU   = 8'b00111_010;
  localparam logic [7:0] CTL_TO   = 8'b00111_011;

  // A halt request arriving in the same cycle the MC op finishes also counts as pending.
  assign pend_now = pend_q | HaltReq;

  always_comb begin
    ctl     = 8'b0;
    state_d = state_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    case (state_q)
      ST_RUN: begin
        if (MCStart) begin
          ctl     = CTL_MC;
          state_d = ST_MC;
          cnt_d   = '0;
          pend_d  = HaltReq;
        end else begin
          if (BranchTaken)        ctl = CTL_BR;
          else if (LoadUseHazard) ctl = CTL_LU;
          else                    ctl = CTL_ALL;
          if (HaltReq) state_d = ST_HALT;
        end
      end
      ST_MC: begin
        pend_d = pend_now;
        if (MCDone || cnt_q == CNT_LAST) begin
          ctl     = MCDone ? CTL_ALL : CTL_TO;
          to_d    = to_q | ~MCDone;
          state_d = pend_now ? ST_HALT : ST_RUN;
          pend_d  = 1'b0;
        end else begin
          ctl   = CTL_MC;
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HALT: begin
        if (ResumeReq && !HaltReq) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_RUN;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      busy_q  <= (state_d == ST_MC);
    end
  end

  assign {PCWrite, EnIFID, EnIDEX, EnEXMEM, EnMEMWB, FlushIFID, FlushIDEX, FlushEXMEM} =
         ctl & {8{Reset}};
  assign MCBusy  = busy_q;
  assign Timeout = to_q;
  assign State   = state_q;

`ifdef STALL_COUNTER_EN
  logic [CNT_WIDTH-1:0] stall_q;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset)                      stall_q <= '0;
    else if (ClearCount)             stall_q <= '0;
    else if (!PCWrite && !(&stall_q)) stall_q <= stall_q + 1'b1;
  end

  assign StallCount = stall_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed + random bench for pipeline_hazard_controller against a cycle-level behavioural model.
module tb_pipeline_hazard_controller;

  localparam int TO = 8;
  localparam int CNTW = 32;

  logic CLK = 1'b0;
  logic Reset, LoadUseHazard, BranchTaken, MCStart, MCDone, HaltReq, ResumeReq;
  logic PCWrite, EnIFID, EnIDEX, EnEXMEM, EnMEMWB, FlushIFID, FlushIDEX, FlushEXMEM;
  logic MCBusy, Timeout;
  logic [1:0] State;
`ifdef STALL_COUNTER_EN
  logic ClearCount;
  logic [CNTW-1:0] StallCount;
`endif

  always #5 CLK = ~CLK;

  pipeline_hazard_controller #(.MC_TIMEOUT(TO), .CNT_WIDTH(CNTW)) dut (
    .CLK(CLK), .Reset(Reset), .LoadUseHazard(LoadUseHazard), .BranchTaken(BranchTaken),
    .MCStart(MCStart), .MCDone(MCDone), .HaltReq(HaltReq), .ResumeReq(ResumeReq),
`ifdef STALL_COUNTER_EN
    .ClearCount(ClearCount), .StallCount(StallCount),
`endif
    .PCWrite(PCWrite), .EnIFID(EnIFID), .EnIDEX(EnIDEX), .EnEXMEM(EnEXMEM), .EnMEMWB(EnMEMWB),
    .FlushIFID(FlushIFID), .FlushIDEX(FlushIDEX), .FlushEXMEM(FlushEXMEM),
    .MCBusy(MCBusy), .Timeout(Timeout), .State(State)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Model state
  localparam int M_RUN = 0, M_MC = 1, M_HALT = 2;
  int      m_mode;
  int      m_mc_cycles;
  bit      m_pend;
  bit      m_timeout;
  longint  m_stall;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_RUN; m_mc_cycles = 0; m_pend = 0; m_timeout = 0; m_stall = 0;
  endtask

  // Expected {PCWrite,EnIFID,EnIDEX,EnEXMEM,EnMEMWB,FlushIFID,FlushIDEX,FlushEXMEM}
  function automatic logic [7:0] model_out(input bit rst, lu, br, mcs, mcd);
    logic pcw, eif, eid, eex, emw, fif, fid, fex;
    {pcw, eif, eid, eex, emw, fif, fid, fex} = 8'b0;
    if (rst) begin
      if (m_mode == M_RUN) begin
        if (mcs) begin
          eex = 1; emw = 1; fex = 1;
        end else if (br) begin
          pcw = 1; eif = 1; eid = 1; eex = 1; emw = 1; fif = 1; fid = 1;
        end else if (lu) begin
          eid = 1; fid = 1; eex = 1; emw = 1;
        end else begin
          pcw = 1; eif = 1; eid = 1; eex = 1; emw = 1;
        end
      end else if (m_mode == M_MC) begin
        if (mcd) begin
          pcw = 1; eif = 1; eid = 1; eex = 1; emw = 1;
        end else if (m_mc_cycles == TO - 1) begin
          eid = 1; fid = 1; eex = 1; emw = 1; fex = 1;
        end else begin
          eex = 1; emw = 1; fex = 1;
        end
      end
    end
    return {pcw, eif, eid, eex, emw, fif, fid, fex};
  endfunction

  task automatic model_clock(input bit lu, br, mcs, mcd, hr, rr, cc, input bit pcw);
    lu = lu; br = br;
    if (cc) m_stall = 0;
    else if (!pcw && m_stall != 64'hFFFF_FFFF) m_stall++;
    case (m_mode)
      M_RUN: begin
        if (mcs) begin m_mode = M_MC; m_mc_cycles = 0; m_pend = hr; end
        else if (hr) m_mode = M_HALT;
      end
      M_MC: begin
        m_pend = m_pend | hr;
        if (mcd || m_mc_cycles == TO - 1) begin
          if (!mcd) m_timeout = 1;
          m_mode = m_pend ? M_HALT : M_RUN;
          m_pend = 0;
        end else m_mc_cycles++;
      end
      default: if (rr && !hr) m_mode = M_RUN;
    endcase
  endtask

  task automatic step(input bit rst, lu, br, mcs, mcd, hr, rr, cc);
    logic [7:0] exp_o;
    Reset = rst; LoadUseHazard = lu; BranchTaken = br; MCStart = mcs;
    MCDone = mcd; HaltReq = hr; ResumeReq = rr;
`ifdef STALL_COUNTER_EN
    ClearCount = cc;
`endif
    if (!rst) model_reset();
    @(negedge CLK);
    exp_o = model_out(rst, lu, br, mcs, mcd);
    chk("ctl", {24'b0, PCWrite, EnIFID, EnIDEX, EnEXMEM, EnMEMWB, FlushIFID, FlushIDEX, FlushEXMEM},
        {24'b0, exp_o});
    chk("state", {30'b0, State}, 32'(m_mode));
    chk("mcbusy", {31'b0, MCBusy}, {31'b0, m_mode == M_MC});
    chk("timeout", {31'b0, Timeout}, {31'b0, m_timeout});
`ifdef STALL_COUNTER_EN
    chk("stallcnt", StallCount, m_stall[31:0]);
`endif
    @(posedge CLK);
    if (rst) model_clock(lu, br, mcs, mcd, hr, rr, cc, exp_o[7]);
    #1;
  endtask

  initial begin
    model_reset();
    // 1: reset three cycles, then idle
    repeat (3) step(0, 1, 1, 1, 0, 1, 0, 0);
    repeat (2) step(1, 0, 0, 0, 0, 0, 0, 0);
    // 2: single load-use cycle
    step(1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    // 3: branch wins over load-use
    step(1, 1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    // 4: multi-cycle op finishing on its fifth MC cycle
    step(1, 1, 1, 1, 0, 0, 0, 0);
    repeat (4) step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    // MCDone on the last counter value beats timeout
    step(1, 0, 0, 1, 0, 0, 0, 0);
    repeat (TO - 1) step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0, 0);
    // 5: timeout, then stays sticky
    step(1, 0, 0, 1, 0, 0, 0, 0);
    repeat (TO) step(1, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0, 0, 0, 0, 0);
    // 6: halt during MC, done -> HALT, resume blocked while HaltReq held, then resume
    step(1, 0, 0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0, 0);
    step(1, 0, 1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 1, 0);
    step(1, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    // halt straight from RUN with a branch in the same cycle
    step(1, 0, 1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1, 0);
    // reset mid-MC
    step(1, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 79) != 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 11) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 24) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
